hs4_req_tx: RTL

- Source-domain initiator of a 4-phase level handshake (req/ack) for crossing a multi-bit word into an unrelated clock domain.
- Accepts a word by valid/ready, holds it stable on data_d, raises a registered req level, and waits for the remote ack level; a sync_cell synchronizes ack internally.
- Pairs with a destination-side responder that samples data_d once its synchronized copy of req goes high.
- Optional timeout aborts a transfer whose ack never arrives.

---
 rtl/cdc_pkg.sv | 12 +
 rtl/sync_cell.sv | 25 ++
 rtl/hs4_req_tx.sv | 93 +++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the clock-domain-crossing handshake blocks.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } hs4_state_e;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_cell.sv
// Multi-flop level synchronizer for a single asynchronous bit.
module sync_cell
    import cdc_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], in};
        end
    end

    assign out = sync_q[STAGES-1];

endmodule

// File: rtl/hs4_req_tx.sv
// Source-side initiator of a 4-phase req/ack handshake that carries one word
// into an unrelated clock domain, with an optional abort when ack never arrives.
module hs4_req_tx
    import cdc_pkg::*;
#(
    parameter  int DW      = 8,
    parameter  int TIMEOUT = 255,
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] data_d,
    output logic          req_d,
    input  logic          ack_a,
    output logic          done,
    output logic          err,
    output logic          busy
);

    localparam bit               TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    hs4_state_e       state;
    logic [CNT_W-1:0] count;
    logic             abort_q;
    logic             ack_s;

    sync_cell #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (ack_a),
        .out   (ack_s)
    );

    // A stale ack still high from the remote side must fall before a new word is taken.
    assign in_ready = rst_n & (state == IDLE) & ~ack_s;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_d   <= 1'b0;
            data_d  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            count   <= '0;
            abort_q <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_d  <= in_data;
                        req_d   <= 1'b1;
                        count   <= '0;
                        abort_q <= 1'b0;
                        state   <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (count != '1) begin
                        count <= count + 1'b1;
                    end
                    // A real ack wins over a timeout landing in the same cycle.
                    if (ack_s) begin
                        req_d   <= 1'b0;
                        abort_q <= 1'b0;
                        state   <= REQ_LO;
                    end else if (TO_EN && (count == CNT_LAST)) begin
                        req_d   <= 1'b0;
                        abort_q <= 1'b1;
                        state   <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        state <= IDLE;
                        done  <= ~abort_q;
                        err   <= abort_q;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
